// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/data memory port arbiter.
package mem_arb_pkg;

    localparam int MAX_WAIT_DEFAULT = 3;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data port and unified-memory signals around the arbiter.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic              if_req;
    logic [AW-1:0]     if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DW-1:0]     if_rdata;

    logic              dm_req;
    logic              dm_we;
    logic [DW/8-1:0]   dm_be;
    logic [AW-1:0]     dm_addr;
    logic [DW-1:0]     dm_wdata;
    logic              dm_gnt;
    logic              dm_rvalid;
    logic [DW-1:0]     dm_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [DW/8-1:0]   mem_be;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [DW-1:0]     mem_rdata;

    logic              stall_if;
    logic              stall_mem;

    // Arbiter side
    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_be, dm_addr, dm_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
               mem_en, mem_we, mem_be, mem_addr, mem_wdata, stall_if, stall_mem
    );

    // Pipeline/memory side
    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_be, dm_addr, dm_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
               mem_en, mem_we, mem_be, mem_addr, mem_wdata, stall_if, stall_mem
    );
endinterface

// File: rtl/mem_port_arbiter_wait_counter.sv
// Saturating wait counter: clear has priority over increment, holds at MAX.
module arb_wait_counter #(
    parameter int MAX = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic inc_i,
    input  logic clr_i,
    output logic at_max_o
);
    localparam int W = (MAX > 0) ? $clog2(MAX + 1) : 1;

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != W'(MAX))) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_max_o = (cnt_q == W'(MAX));
endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and the MEM stage, with
// bounded fetch starvation and one-cycle read-data return to the granted owner.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);
    localparam int BW = DW / 8;

    owner_e rd_owner_q, rd_owner_d;
    logic   at_max;
    logic   if_win;

    arb_wait_counter #(.MAX(MAX_WAIT)) u_wait_cnt (
        .clk      (clk),
        .rst      (rst),
        .inc_i    (bus.if_req & ~bus.if_gnt),
        .clr_i    (bus.if_gnt | ~bus.if_req),
        .at_max_o (at_max)
    );

    // Data beats fetch (older instruction) unless fetch has waited MAX_WAIT cycles.
    assign if_win = bus.if_req & (at_max | ~bus.dm_req);

    always_comb begin
        bus.if_gnt    = 1'b0;
        bus.dm_gnt    = 1'b0;
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_be    = {BW{1'b0}};
        bus.mem_addr  = {AW{1'b0}};
        bus.mem_wdata = {DW{1'b0}};
        rd_owner_d    = OWN_NONE;

        if (!rst) begin
            if (if_win) begin
                bus.if_gnt   = 1'b1;
                bus.mem_en   = 1'b1;
                bus.mem_be   = {BW{1'b1}};
                bus.mem_addr = bus.if_addr;
                rd_owner_d   = OWN_IF;
            end else if (bus.dm_req) begin
                bus.dm_gnt    = 1'b1;
                bus.mem_en    = 1'b1;
                bus.mem_we    = bus.dm_we;
                bus.mem_be    = bus.dm_be;
                bus.mem_addr  = bus.dm_addr;
                bus.mem_wdata = bus.dm_wdata;
                rd_owner_d    = bus.dm_we ? OWN_NONE : OWN_DM;
            end
        end

        bus.stall_if  = bus.if_req & ~bus.if_gnt & ~rst;
        bus.stall_mem = bus.dm_req & ~bus.dm_gnt & ~rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_owner_q <= OWN_NONE;
        end else begin
            rd_owner_q <= rd_owner_d;
        end
    end

    assign bus.if_rvalid = (rd_owner_q == OWN_IF);
    assign bus.dm_rvalid = (rd_owner_q == OWN_DM);
    assign bus.if_rdata  = bus.mem_rdata;
    assign bus.dm_rdata  = bus.mem_rdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a byte-enabled synchronous-read memory model.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

    mem_port_arbiter #(.AW(32), .DW(32), .MAX_WAIT(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] mem [0:255];
    logic [31:0] rdata_q = '0;

    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (bus.mem_be[b]) mem[bus.mem_addr[9:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
            end else begin
                rdata_q <= mem[bus.mem_addr[9:2]];
            end
        end
    end
    assign bus.mem_rdata = rdata_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    endtask

    task automatic drv(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                       input logic [3:0] db, input logic [31:0] da, input logic [31:0] dd);
        bus.if_req   = ir;
        bus.if_addr  = ia;
        bus.dm_req   = dr;
        bus.dm_we    = dw;
        bus.dm_be    = db;
        bus.dm_addr  = da;
        bus.dm_wdata = dd;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drv(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[0]  = 32'h00500093;
        mem[1]  = 32'h00100113;
        mem[2]  = 32'h00208193;
        mem[64] = 32'hDEADBEEF;
        mem[65] = 32'h11111111;

        // Reset with both requesters active
        rst = 1'b1;
        drv(1'b1, 32'h0, 1'b1, 1'b0, 4'hF, 32'h100, 32'h0);
        step();
        step();
        check("rst_if_gnt",    bus.if_gnt,    0);
        check("rst_dm_gnt",    bus.dm_gnt,    0);
        check("rst_stall_if",  bus.stall_if,  0);
        check("rst_stall_mem", bus.stall_mem, 0);
        check("rst_mem_en",    bus.mem_en,    0);
        check("rst_mem_addr",  bus.mem_addr,  0);
        check("rst_mem_be",    bus.mem_be,    0);
        check("rst_if_rvalid", bus.if_rvalid, 0);
        check("rst_dm_rvalid", bus.dm_rvalid, 0);
        rst = 1'b0;
        idle();

        // Fetch only
        step();
        drv(1'b1, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        check("f0_if_gnt",   bus.if_gnt,   1);
        check("f0_stall_if", bus.stall_if, 0);
        check("f0_mem_we",   bus.mem_we,   0);
        check("f0_mem_be",   bus.mem_be,   4'hF);
        check("f0_mem_addr", bus.mem_addr, 32'h0);
        step();
        drv(1'b1, 32'h4, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        check("f1_if_gnt",    bus.if_gnt,    1);
        check("f1_if_rvalid", bus.if_rvalid, 1);
        check("f1_if_rdata",  bus.if_rdata,  32'h00500093);
        check("f1_stall_if",  bus.stall_if,  0);
        step();
        drv(1'b1, 32'h8, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        check("f2_if_gnt",   bus.if_gnt,   1);
        check("f2_if_rdata", bus.if_rdata, 32'h00100113);
        step();
        idle();
        check("f3_if_rvalid",   bus.if_rvalid, 1);
        check("f3_if_rdata",    bus.if_rdata,  32'h00208193);
        check("idle_mem_en",    bus.mem_en,    0);
        check("idle_mem_we",    bus.mem_we,    0);
        check("idle_mem_be",    bus.mem_be,    0);
        check("idle_mem_addr",  bus.mem_addr,  0);
        check("idle_mem_wdata", bus.mem_wdata, 0);
        step();
        check("f4_if_rvalid", bus.if_rvalid, 0);

        // Load/fetch collision
        drv(1'b1, 32'hC, 1'b1, 1'b0, 4'hF, 32'h100, 32'h0);
        check("col_dm_gnt",    bus.dm_gnt,    1);
        check("col_if_gnt",    bus.if_gnt,    0);
        check("col_stall_if",  bus.stall_if,  1);
        check("col_stall_mem", bus.stall_mem, 0);
        check("col_mem_addr",  bus.mem_addr,  32'h100);
        step();
        drv(1'b1, 32'hC, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        check("col_dm_rvalid", bus.dm_rvalid, 1);
        check("col_dm_rdata",  bus.dm_rdata,  32'hDEADBEEF);
        check("col_if_rvalid", bus.if_rvalid, 0);
        check("col_if_gnt2",   bus.if_gnt,    1);
        step();
        idle();
        check("col_if_rvalid2", bus.if_rvalid, 1);
        step();

        // Store, then load back
        drv(1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h104, 32'h0000ABCD);
        check("st_dm_gnt",    bus.dm_gnt,    1);
        check("st_mem_we",    bus.mem_we,    1);
        check("st_mem_be",    bus.mem_be,    4'b0011);
        check("st_mem_addr",  bus.mem_addr,  32'h104);
        check("st_mem_wdata", bus.mem_wdata, 32'h0000ABCD);
        step();
        drv(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h104, 32'h0);
        check("st_no_rvalid", bus.dm_rvalid, 0);
        step();
        idle();
        check("ld_dm_rvalid", bus.dm_rvalid, 1);
        check("ld_lo_half",   {16'h0, bus.dm_rdata[15:0]}, 32'h0000ABCD);
        check("ld_word",      bus.dm_rdata, 32'h1111ABCD);
        step();

        // Starvation: fetch wins on the 4th contended cycle
        for (int c = 0; c < 6; c++) begin
            drv(1'b1, 32'h10, 1'b1, 1'b0, 4'hF, 32'h100, 32'h0);
            check($sformatf("stv%0d_dm_gnt", c),    bus.dm_gnt,    c != 3);
            check($sformatf("stv%0d_if_gnt", c),    bus.if_gnt,    c == 3);
            check($sformatf("stv%0d_stall_mem", c), bus.stall_mem, c == 3);
            check($sformatf("stv%0d_stall_if", c),  bus.stall_if,  c != 3);
            if (c > 0) begin
                check($sformatf("stv%0d_dm_rvalid", c), bus.dm_rvalid, (c - 1) != 3);
                check($sformatf("stv%0d_if_rvalid", c), bus.if_rvalid, (c - 1) == 3);
            end
            step();
        end
        idle();
        step();

        // Reset mid-read with the wait counter saturated
        for (int c = 0; c < 3; c++) begin
            drv(1'b1, 32'h10, 1'b1, 1'b0, 4'hF, 32'h100, 32'h0);
            check($sformatf("pre%0d_dm_gnt", c), bus.dm_gnt, 1);
            step();
        end
        rst = 1'b1;
        drv(1'b1, 32'h10, 1'b1, 1'b0, 4'hF, 32'h100, 32'h0);
        check("mrst_if_gnt",    bus.if_gnt,    0);
        check("mrst_dm_gnt",    bus.dm_gnt,    0);
        check("mrst_stall_if",  bus.stall_if,  0);
        check("mrst_stall_mem", bus.stall_mem, 0);
        step();
        check("mrst_dm_rvalid", bus.dm_rvalid, 0);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            drv(1'b1, 32'h10, 1'b1, 1'b0, 4'hF, 32'h100, 32'h0);
            check($sformatf("post%0d_dm_gnt", c), bus.dm_gnt, c != 3);
            check($sformatf("post%0d_if_gnt", c), bus.if_gnt, c == 3);
            step();
        end
        idle();
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
